pwm_timer_bank: RTL and testbench

Multi-channel PWM generator with an internal period counter and double-buffered (shadow) compare registers. It is the successor to the single-channel compare timer, which relied on an external counter. Each channel asserts its output on a rise compare match and deasserts it on a fall compare match. Compare and period updates take effect glitch-free, only at counter wrap. It sits between the control register block and the gate-drive pins.

---
 rtl/pwm_timer_bank.sv | 166 ++++++++++++++++
 tb/tb_pwm_timer_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_timer_bank.sv
// pwm_timer_bank: multi-channel PWM generator with an internal period counter and
// double-buffered period/compare registers that swap in only at counter wrap.
// Optional feature macro: PWM_UPDOWN_EN adds count_mode for centre-aligned up/down counting.
module pwm_timer_bank #(
  parameter int unsigned bitwidth       = 10,
  parameter int unsigned channels       = 4,
  parameter int unsigned default_period = 1023,
  localparam int unsigned chan_w        = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
`ifdef PWM_UPDOWN_EN
  input  logic                count_mode,
`endif
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [chan_w-1:0]   wr_channel,
  input  logic [bitwidth-1:0] wr_data,
  input  logic                commit,
  input  logic [channels-1:0] channel_enable,
  output logic [bitwidth-1:0] counter,
  output logic                wrap,
  output logic                update_pending,
  output logic [channels-1:0] pwm_out
);

  localparam logic [bitwidth-1:0] def_period = bitwidth'(default_period);
  localparam logic [bitwidth-1:0] one        = bitwidth'(1);

  logic [bitwidth-1:0] counter_q, counter_d;
  logic [bitwidth-1:0] period_q, period_stage_q, period_next;
  logic [bitwidth-1:0] rise_q       [channels];
  logic [bitwidth-1:0] fall_q       [channels];
  logic [bitwidth-1:0] rise_stage_q [channels];
  logic [bitwidth-1:0] fall_stage_q [channels];
  logic                pending_q;
  logic [channels-1:0] pwm_q, pwm_d;
  logic                wrap_c, load, rise_ok, fall_ok;
  logic                chan_hit;

`ifdef PWM_UPDOWN_EN
  logic mode_q, mode_d;
  logic down_q, down_d;
`endif

  // Writes to a channel index beyond the bank are dropped.
  assign chan_hit = 32'(wr_channel) < channels;

  // Counter sequencing, wrap detection and shadow-load decision.
  always_comb begin
    counter_d = counter_q;
`ifdef PWM_UPDOWN_EN
    mode_d  = mode_q;
    down_d  = down_q;
    rise_ok = !mode_q || !down_q;
    fall_ok = !mode_q || down_q;
    wrap_c  = enable && (mode_q ? (down_q && counter_q == '0) : (counter_q == period_q));
`else
    rise_ok = 1'b1;
    fall_ok = 1'b1;
    wrap_c  = enable && (counter_q == period_q);
`endif
    // A commit arriving on the wrap cycle itself still loads at that wrap.
    load        = wrap_c && (pending_q || commit);
    period_next = load ? period_stage_q : period_q;
    if (enable) begin
`ifdef PWM_UPDOWN_EN
      if (wrap_c) begin
        mode_d = count_mode;
        // Leaving an up-only wrap at 0 marks the bottom should up/down take over.
        down_d = 1'b1;
        if (mode_q) begin
          counter_d = (period_next == '0) ? '0 : one;
          down_d    = (period_next == '0);
        end else begin
          counter_d = '0;
        end
      end else if (mode_q && down_q) begin
        counter_d = counter_q - one;
      end else if (mode_q && counter_q == period_q) begin
        counter_d = counter_q - one;
        down_d    = 1'b1;
      end else begin
        counter_d = counter_q + one;
      end
`else
      counter_d = wrap_c ? '0 : counter_q + one;
`endif
    end
  end

  // Per-channel set/clear on compare match; fall has priority over rise.
  always_comb begin
    pwm_d = pwm_q;
    for (int unsigned i = 0; i < channels; i++) begin
      if (!channel_enable[i]) begin
        pwm_d[i] = 1'b0;
      end else if (enable) begin
        if (fall_ok && counter_q == fall_q[i]) begin
          pwm_d[i] = 1'b0;
        end else if (rise_ok && counter_q == rise_q[i]) begin
          pwm_d[i] = 1'b1;
        end
      end
    end
  end

  // State update: counter, staging writes, active load at wrap, pending flag, outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_q      <= '0;
      period_q       <= def_period;
      period_stage_q <= def_period;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      for (int unsigned i = 0; i < channels; i++) begin
        rise_q[i]       <= '0;
        fall_q[i]       <= '0;
        rise_stage_q[i] <= '0;
        fall_stage_q[i] <= '0;
      end
`ifdef PWM_UPDOWN_EN
      // Reset is treated as a bottom-of-period point, so the mode is sampled here.
      mode_q <= count_mode;
      down_q <= 1'b1;
`endif
    end else begin
      counter_q <= counter_d;
      pwm_q     <= pwm_d;
`ifdef PWM_UPDOWN_EN
      mode_q <= mode_d;
      down_q <= down_d;
`endif
      // Load reads staging before this edge's write lands, so a same-cycle write waits.
      if (load) begin
        period_q <= period_stage_q;
        for (int unsigned i = 0; i < channels; i++) begin
          rise_q[i] <= rise_stage_q[i];
          fall_q[i] <= fall_stage_q[i];
        end
      end
      if (enable) begin
        if (load) begin
          pending_q <= 1'b0;
        end else if (commit) begin
          pending_q <= 1'b1;
        end
      end
      if (wr_en) begin
        case (wr_sel)
          2'd0: period_stage_q <= wr_data;
          2'd1: if (chan_hit) rise_stage_q[wr_channel] <= wr_data;
          2'd2: if (chan_hit) fall_stage_q[wr_channel] <= wr_data;
          default: ;
        endcase
      end
    end
  end

  assign counter        = counter_q;
  assign wrap           = wrap_c;
  assign update_pending = pending_q;
  assign pwm_out        = pwm_q;

endmodule

// File: tb/tb_pwm_timer_bank.sv
// tb_pwm_timer_bank: directed stimulus pushes per-cycle expected outputs into a scoreboard
// queue; a monitor pops one entry every falling edge and compares it with the DUT.
module tb_pwm_timer_bank;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [1:0] wr_channel;
  logic [9:0] wr_data;
  logic       commit;
  logic [3:0] channel_enable;
  logic [9:0] counter;
  logic       wrap;
  logic       update_pending;
  logic [3:0] pwm_out;
`ifdef PWM_UPDOWN_EN
  logic       count_mode;
`endif

  pwm_timer_bank #(
    .bitwidth       (10),
    .channels       (4),
    .default_period (1023)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
`ifdef PWM_UPDOWN_EN
    .count_mode     (count_mode),
`endif
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_channel     (wr_channel),
    .wr_data        (wr_data),
    .commit         (commit),
    .channel_enable (channel_enable),
    .counter        (counter),
    .wrap           (wrap),
    .update_pending (update_pending),
    .pwm_out        (pwm_out)
  );

  // Clock starts high so the first falling edge samples the cycle before the first rise.
  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         chk;
    logic [9:0] counter;
    logic       wrap;
    logic       pend;
    logic [3:0] pwm;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // One expected entry per cycle, then advance to just after the next rising edge.
  task automatic tick(input string nm, input bit chk, input logic [9:0] c, input logic w,
                      input logic p, input logic [3:0] pw);
    exp_t e;
    e.name = nm;
    e.chk = chk;
    e.counter = c;
    e.wrap = w;
    e.pend = p;
    e.pwm = pw;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Staging write while the counter is idle at 0.
  task automatic stage_write(input logic [1:0] sel, input logic [1:0] ch, input logic [9:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_channel = ch;
    wr_data = d;
    tick("stage_idle", 1'b1, 10'd0, 1'b0, 1'b0, 4'b0000);
    wr_en = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checks += 4;
          if (counter !== e.counter) begin
            failures++;
            $display("FAIL %s cyc=%0d counter actual=%0d required=%0d", e.name, cycle, counter,
                     e.counter);
          end
          if (wrap !== e.wrap) begin
            failures++;
            $display("FAIL %s cyc=%0d wrap actual=%b required=%b", e.name, cycle, wrap, e.wrap);
          end
          if (update_pending !== e.pend) begin
            failures++;
            $display("FAIL %s cyc=%0d update_pending actual=%b required=%b", e.name, cycle,
                     update_pending, e.pend);
          end
          if (pwm_out !== e.pwm) begin
            failures++;
            $display("FAIL %s cyc=%0d pwm_out actual=%b required=%b", e.name, cycle, pwm_out,
                     e.pwm);
          end
        end
      end
      cycle++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0;
    int         f0;
    logic [3:0] pw;
    logic       pend;

    reset = 1'b1;
    enable = 1'b0;
    wr_en = 1'b0;
    wr_sel = 2'd0;
    wr_channel = 2'd0;
    wr_data = 10'd0;
    commit = 1'b0;
    channel_enable = 4'b1111;
`ifdef PWM_UPDOWN_EN
    count_mode = 1'b0;
`endif
    tick("pre_reset", 1'b0, 10'd0, 1'b0, 1'b0, 4'b0000);
    tick("reset", 1'b1, 10'd0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;

    // P=9, ch0 2/6, ch1 4/4, ch2 0/5, ch3 compares beyond P.
    stage_write(2'd0, 2'd0, 10'd9);
    stage_write(2'd1, 2'd0, 10'd2);
    stage_write(2'd2, 2'd0, 10'd6);
    stage_write(2'd1, 2'd1, 10'd4);
    stage_write(2'd2, 2'd1, 10'd4);
    stage_write(2'd1, 2'd2, 10'd0);
    stage_write(2'd2, 2'd2, 10'd5);
    stage_write(2'd1, 2'd3, 10'd12);
    stage_write(2'd2, 2'd3, 10'd15);

    // Commit under the default period: load only happens at counter 1023.
    enable = 1'b1;
    commit = 1'b1;
    tick("commit_dflt", 1'b1, 10'd0, 1'b0, 1'b0, 4'b0000);
    commit = 1'b0;
    for (int k = 1; k <= 1023; k++) begin
      tick("dflt_period", 1'b1, 10'(k), k == 1023, 1'b1, 4'b0000);
    end

    // Nine periods of P=9 with mid-period updates, hold, and channel disable.
    for (int q = 1; q <= 9; q++) begin
      for (int c = 0; c <= 9; c++) begin
        r0 = (q >= 6) ? 2 : 3;
        f0 = (q >= 5) ? 8 : 6;
        pw[0] = (c >= r0 && c <= f0);
        if (q == 7 && c >= 5) pw[0] = 1'b0;
        if (q == 8) pw[0] = 1'b0;
        pw[1] = 1'b0;
        pw[2] = (c >= 1 && c <= 5);
        pw[3] = 1'b0;
        pend = (q == 4 && c >= 4) || (q == 9 && c >= 6);
        channel_enable[0] = !((q == 7 && c >= 4) || (q == 8 && c <= 4));
        if (q == 2 && c == 9) begin
          enable = 1'b0;
          repeat (2) tick("hold", 1'b1, 10'd9, 1'b0, 1'b0, pw);
          enable = 1'b1;
        end
        if (q == 4 && c == 3) begin
          wr_en = 1'b1;
          wr_sel = 2'd2;
          wr_channel = 2'd0;
          wr_data = 10'd8;
          commit = 1'b1;
        end
        if (q == 4 && c == 9) begin
          wr_en = 1'b1;
          wr_sel = 2'd1;
          wr_channel = 2'd0;
          wr_data = 10'd1;
        end
        if (q == 5 && c == 9) commit = 1'b1;
        if (q == 9 && c == 2) begin
          wr_en = 1'b1;
          wr_sel = 2'd0;
          wr_data = 10'd0;
        end
        if (q == 9 && c == 5) commit = 1'b1;
        tick("up_period", 1'b1, 10'(c), c == 9, pend, pw);
        wr_en = 1'b0;
        commit = 1'b0;
      end
    end

    // P=0: counter pinned at 0, wrap every cycle; ch2 (rise 0) goes high and stays.
    for (int i = 0; i <= 9; i++) begin
      if (i == 8) begin
        wr_en = 1'b1;
        wr_sel = 2'd0;
        wr_data = 10'd9;
      end
      if (i == 9) commit = 1'b1;
      tick("p_zero", 1'b1, 10'd0, 1'b1, 1'b0, {1'b0, i >= 1, 2'b00});
      wr_en = 1'b0;
      commit = 1'b0;
    end

    // Back at P=9; reset while pwm_out and update_pending are both high.
    for (int c = 0; c <= 3; c++) begin
      if (c == 2) commit = 1'b1;
      if (c == 3) reset = 1'b1;
      tick("pre_reset_run", 1'b1, 10'(c), 1'b0, c == 3, {1'b0, 1'b1, 1'b0, c >= 2});
      commit = 1'b0;
    end
    reset = 1'b0;
    for (int k = 0; k <= 1024; k++) begin
      tick("post_reset", 1'b1, 10'(k % 1024), k == 1023, 1'b0, 4'b0000);
    end

`ifdef PWM_UPDOWN_EN
    // Centre-aligned: P=8, ch0 rise=fall=3, 16-cycle period.
    enable = 1'b0;
    count_mode = 1'b1;
    reset = 1'b1;
    tick("ud_reset", 1'b0, 10'd0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;
    stage_write(2'd0, 2'd0, 10'd8);
    stage_write(2'd1, 2'd0, 10'd3);
    stage_write(2'd2, 2'd0, 10'd3);
    enable = 1'b1;
    commit = 1'b1;
    for (int t = 0; t < 48; t++) begin
      int tt;
      tt = t % 16;
      tick("updown", 1'b1, 10'((tt <= 8) ? tt : 16 - tt), tt == 0, 1'b0,
           {3'b000, tt >= 4 && tt <= 13});
      commit = 1'b0;
    end
`endif

    @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
